// File: rtl/scan_addr_ctrl_if.sv
// Frame-scan handshake and address bus between the scan controller and the pixel pipeline.
// The stall signal exists only when SCAN_STALL_EN is defined.
interface scan_addr_ctrl_if #(
    parameter int ROW_W = 8,
    parameter int COL_W = 8
);
    logic             start;
`ifdef SCAN_STALL_EN
    logic             stall;
`endif
    logic             act;
    logic             rd;
    logic             wr;
    logic [ROW_W-1:0] addr_row_r;
    logic [COL_W-1:0] addr_col_r;
    logic [ROW_W-1:0] addr_row_w;
    logic [COL_W-1:0] addr_col_w;
    logic             busy;
    logic             done;

`ifdef SCAN_STALL_EN
    modport master (input start, input stall,
                    output act, output rd, output wr,
                    output addr_row_r, output addr_col_r,
                    output addr_row_w, output addr_col_w,
                    output busy, output done);
    modport slave  (output start, output stall,
                    input act, input rd, input wr,
                    input addr_row_r, input addr_col_r,
                    input addr_row_w, input addr_col_w,
                    input busy, input done);
`else
    modport master (input start,
                    output act, output rd, output wr,
                    output addr_row_r, output addr_col_r,
                    output addr_row_w, output addr_col_w,
                    output busy, output done);
    modport slave  (output start,
                    input act, input rd, input wr,
                    input addr_row_r, input addr_col_r,
                    input addr_row_w, input addr_col_w,
                    input busy, input done);
`endif
endinterface

// File: rtl/scan_addr_ctrl.sv
// Raster-scan read/write address controller with a LAT-deep write delay and busy/done handshake.
// Optional freeze input compiled in with SCAN_STALL_EN.
module scan_addr_ctrl #(
    parameter int ROW_W = 8,
    parameter int COL_W = 8,
    parameter int ROWS  = 256,
    parameter int COLS  = 256,
    parameter int LAT   = 8
) (
    input  logic             clk,
    input  logic             rst,
    scan_addr_ctrl_if.master bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    localparam int N     = ROWS * COLS;
    localparam int CNT_W = $clog2(N + 1);

    logic [1:0]       state_r;
    logic [1:0]       state_s;
    logic [CNT_W-1:0] rd_cnt_r;
    logic [CNT_W-1:0] rd_cnt_s;
    logic [CNT_W-1:0] wr_cnt_r;
    logic [CNT_W-1:0] wr_cnt_s;
    logic             rd_v_r;
    logic [LAT-1:0]   dl_r;
    logic [LAT-1:0]   dl_s;
    logic             wr_s;
    logic             adv_s;
    logic [ROW_W-1:0] rrow_r;
    logic [COL_W-1:0] rcol_r;
    logic [ROW_W-1:0] wrow_r;
    logic [COL_W-1:0] wcol_r;

    // Row-major successor of a pixel coordinate, wrapping to (0,0) after the last pixel.
    function automatic logic [ROW_W+COL_W-1:0] next_pix(input logic [ROW_W-1:0] row,
                                                         input logic [COL_W-1:0] col);
        logic [ROW_W-1:0] nrow;
        logic [COL_W-1:0] ncol;
        if (col == COL_W'(COLS - 1)) begin
            ncol = '0;
            if (row == ROW_W'(ROWS - 1)) begin
                nrow = '0;
            end else begin
                nrow = row + ROW_W'(1);
            end
        end else begin
            ncol = col + COL_W'(1);
            nrow = row;
        end
        return {nrow, ncol};
    endfunction

`ifdef SCAN_STALL_EN
    assign adv_s = ~bus.stall;
`else
    assign adv_s = 1'b1;
`endif

    // Delay line contents after the next advancing edge; its top bit is the next write strobe.
    always_comb begin
        dl_s    = '0;
        dl_s[0] = rd_v_r;
        for (int i = 1; i < LAT; i++) begin
            dl_s[i] = dl_r[i-1];
        end
    end

    assign wr_s = dl_s[LAT-1];

    // FSM next state plus read/write pixel counters used to find the last read and last write.
    always_comb begin
        state_s  = state_r;
        rd_cnt_s = rd_cnt_r;
        if (wr_s) begin
            wr_cnt_s = wr_cnt_r + CNT_W'(1);
        end else begin
            wr_cnt_s = wr_cnt_r;
        end
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (rd_cnt_r == CNT_W'(N - 1)) begin
                    state_s  = DRAIN;
                    rd_cnt_s = '0;
                end else begin
                    state_s  = RUN;
                    rd_cnt_s = rd_cnt_r + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (wr_s && (wr_cnt_r == CNT_W'(N - 1))) begin
                    state_s  = DONE;
                    wr_cnt_s = '0;
                end else begin
                    state_s  = DRAIN;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Scan state; everything holds on a stalled edge so the whole frame simply stretches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= IDLE;
            rd_cnt_r <= '0;
            wr_cnt_r <= '0;
            rd_v_r   <= 1'b0;
            dl_r     <= '0;
            rrow_r   <= '0;
            rcol_r   <= '0;
            wrow_r   <= '0;
            wcol_r   <= '0;
        end else if (adv_s) begin
            state_r  <= state_s;
            rd_cnt_r <= rd_cnt_s;
            wr_cnt_r <= wr_cnt_s;
            rd_v_r   <= (state_r == RUN);
            dl_r     <= dl_s;
            if (rd_v_r) begin
                {rrow_r, rcol_r} <= next_pix(rrow_r, rcol_r);
            end
            if (dl_r[LAT-1]) begin
                {wrow_r, wcol_r} <= next_pix(wrow_r, wcol_r);
            end
        end
    end

    // Registered strobes: forced low on stalled edges, busy holds so it never drops mid-stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.rd   <= 1'b0;
            bus.act  <= 1'b0;
            bus.wr   <= 1'b0;
            bus.done <= 1'b0;
            bus.busy <= 1'b0;
        end else if (adv_s) begin
            bus.rd   <= (state_r == RUN);
            bus.act  <= rd_v_r;
            bus.wr   <= wr_s;
            bus.done <= (state_r == DONE);
            bus.busy <= (state_r == RUN) || (state_r == DRAIN);
        end else begin
            bus.rd   <= 1'b0;
            bus.act  <= 1'b0;
            bus.wr   <= 1'b0;
            bus.done <= 1'b0;
        end
    end

    assign bus.addr_row_r = rrow_r;
    assign bus.addr_col_r = rcol_r;
    assign bus.addr_row_w = wrow_r;
    assign bus.addr_col_w = wcol_r;
endmodule

// File: tb/tb_scan_addr_ctrl.sv
// Directed bench for scan_addr_ctrl: 4x3/LAT2, 1x2/LAT5 and default 256x256/LAT8 instances.
// The stall scenario is included only when SCAN_STALL_EN is defined.
module tb_scan_addr_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    scan_addr_ctrl_if #(.ROW_W(2), .COL_W(2)) a_if ();
    scan_addr_ctrl_if #(.ROW_W(1), .COL_W(1)) b_if ();
    scan_addr_ctrl_if #(.ROW_W(8), .COL_W(8)) c_if ();

    scan_addr_ctrl #(.ROW_W(2), .COL_W(2), .ROWS(4), .COLS(3), .LAT(2)) dut_a (
        .clk(clk), .rst(rst), .bus(a_if));
    scan_addr_ctrl #(.ROW_W(1), .COL_W(1), .ROWS(1), .COLS(2), .LAT(5)) dut_b (
        .clk(clk), .rst(rst), .bus(b_if));
    scan_addr_ctrl #(.ROW_W(8), .COL_W(8), .ROWS(256), .COLS(256), .LAT(8)) dut_c (
        .clk(clk), .rst(rst), .bus(c_if));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // 4x3 LAT=2 frame; with stall, edges 5 and 6 are frozen; with repulse, start is re-driven mid-scan and in DONE.
    task automatic run_a(input bit use_stall, input bit repulse, input string tag);
        int nrd;
        int nwr;
        int ndone;
        int s;
        bit st;
        nrd = 0; nwr = 0; ndone = 0;
        @(posedge clk); #1 a_if.start = 1'b1;
        for (int k = 0; k <= 18; k++) begin
            @(posedge clk); #1;
            if (!use_stall || k < 5) begin
                s = k; st = 1'b0;
            end else if (k <= 6) begin
                s = 4; st = 1'b1;
            end else begin
                s = k - 2; st = 1'b0;
            end
            chk({tag, " rd"},   a_if.rd,   32'(!st && s >= 1 && s <= 12));
            chk({tag, " wr"},   a_if.wr,   32'(!st && s >= 3 && s <= 14));
            chk({tag, " act"},  a_if.act,  32'(!st && s >= 2 && s <= 13));
            chk({tag, " done"}, a_if.done, 32'(!st && s == 15));
            chk({tag, " busy"}, a_if.busy, 32'(s >= 1 && s <= 14));
            if (s >= 1 && s <= 12) begin
                chk({tag, " rrow"}, a_if.addr_row_r, 32'((s - 1) / 3));
                chk({tag, " rcol"}, a_if.addr_col_r, 32'((s - 1) % 3));
            end else begin
                chk({tag, " rrow idle"}, a_if.addr_row_r, 32'd0);
                chk({tag, " rcol idle"}, a_if.addr_col_r, 32'd0);
            end
            if (s >= 3 && s <= 14) begin
                chk({tag, " wrow"}, a_if.addr_row_w, 32'((s - 3) / 3));
                chk({tag, " wcol"}, a_if.addr_col_w, 32'((s - 3) % 3));
            end else begin
                chk({tag, " wrow idle"}, a_if.addr_row_w, 32'd0);
                chk({tag, " wcol idle"}, a_if.addr_col_w, 32'd0);
            end
            nrd += int'(a_if.rd);
            nwr += int'(a_if.wr);
            ndone += int'(a_if.done);
            a_if.start = repulse && (k == 2 || k == 9 || k == 14);
`ifdef SCAN_STALL_EN
            a_if.stall = use_stall && (k == 4 || k == 5);
`endif
        end
        a_if.start = 1'b0;
        chk({tag, " reads"},  32'(nrd),   32'd12);
        chk({tag, " writes"}, 32'(nwr),   32'd12);
        chk({tag, " dones"},  32'(ndone), 32'd1);
    endtask

    initial begin
        int nrd;
        int nwr;
        int ndone;
        int novl;
        int done_at;
        checks = 0;
        errors = 0;
        rst = 1'b0;
        a_if.start = 1'b0;
        b_if.start = 1'b0;
        c_if.start = 1'b0;
`ifdef SCAN_STALL_EN
        a_if.stall = 1'b0;
        b_if.stall = 1'b0;
        c_if.stall = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("reset rd",   a_if.rd,   32'd0);
        chk("reset wr",   a_if.wr,   32'd0);
        chk("reset act",  a_if.act,  32'd0);
        chk("reset busy", a_if.busy, 32'd0);
        chk("reset done", a_if.done, 32'd0);
        chk("reset rrow", a_if.addr_row_r, 32'd0);
        chk("reset wcol", a_if.addr_col_w, 32'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle busy", a_if.busy, 32'd0);

        run_a(1'b0, 1'b0, "basic");
        run_a(1'b0, 1'b1, "repulse");
`ifdef SCAN_STALL_EN
        run_a(1'b1, 1'b0, "stall");
`endif

        // Asynchronous reset after edge 7 of a running frame.
        @(posedge clk); #1 a_if.start = 1'b1;
        @(posedge clk); #1 a_if.start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("pre-abort rd", a_if.rd, 32'd1);
        rst = 1'b0;
        #1;
        chk("abort rd",   a_if.rd,   32'd0);
        chk("abort wr",   a_if.wr,   32'd0);
        chk("abort act",  a_if.act,  32'd0);
        chk("abort busy", a_if.busy, 32'd0);
        chk("abort done", a_if.done, 32'd0);
        chk("abort rrow", a_if.addr_row_r, 32'd0);
        chk("abort rcol", a_if.addr_col_r, 32'd0);
        chk("abort wcol", a_if.addr_col_w, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            ndone += int'(a_if.done) + int'(a_if.busy);
        end
        chk("abort no done", 32'(ndone), 32'd0);
        run_a(1'b0, 1'b0, "post-reset");

        // 1x2 LAT=5: reads and writes never overlap.
        nrd = 0; nwr = 0; novl = 0;
        @(posedge clk); #1 b_if.start = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(posedge clk); #1;
            b_if.start = 1'b0;
            chk("small rd",   b_if.rd,   32'(k >= 1 && k <= 2));
            chk("small wr",   b_if.wr,   32'(k >= 6 && k <= 7));
            chk("small act",  b_if.act,  32'(k >= 2 && k <= 3));
            chk("small done", b_if.done, 32'(k == 8));
            chk("small busy", b_if.busy, 32'(k >= 1 && k <= 7));
            chk("small rcol", b_if.addr_col_r, 32'((k == 2) ? 1 : 0));
            chk("small wcol", b_if.addr_col_w, 32'((k == 7) ? 1 : 0));
            chk("small rows", 32'({b_if.addr_row_r, b_if.addr_row_w}), 32'd0);
            nrd += int'(b_if.rd);
            nwr += int'(b_if.wr);
            novl += int'(b_if.rd & b_if.wr);
        end
        chk("small reads",   32'(nrd),  32'd2);
        chk("small writes",  32'(nwr),  32'd2);
        chk("small overlap", 32'(novl), 32'd0);

        // Default 256x256 LAT=8 full frame with row/column wrap points.
        nrd = 0; nwr = 0; ndone = 0; done_at = -1;
        @(posedge clk); #1 c_if.start = 1'b1;
        for (int k = 0; k <= 65548; k++) begin
            @(posedge clk); #1;
            c_if.start = 1'b0;
            nrd += int'(c_if.rd);
            nwr += int'(c_if.wr);
            if (c_if.done) begin
                ndone++;
                done_at = k;
            end
            if (k == 256) begin
                chk("big rrow 255", c_if.addr_row_r, 32'd0);
                chk("big rcol 255", c_if.addr_col_r, 32'd255);
            end
            if (k == 257) begin
                chk("big rrow 256", c_if.addr_row_r, 32'd1);
                chk("big rcol 256", c_if.addr_col_r, 32'd0);
            end
            if (k == 265) begin
                chk("big wrow 256", c_if.addr_row_w, 32'd1);
                chk("big wcol 256", c_if.addr_col_w, 32'd0);
            end
            if (k == 65536) begin
                chk("big last rd",  c_if.rd, 32'd1);
                chk("big rrow end", c_if.addr_row_r, 32'd255);
                chk("big rcol end", c_if.addr_col_r, 32'd255);
            end
            if (k == 65537) begin
                chk("big rd off",    c_if.rd, 32'd0);
                chk("big rrow wrap", c_if.addr_row_r, 32'd0);
                chk("big rcol wrap", c_if.addr_col_r, 32'd0);
            end
            if (k == 65544) begin
                chk("big wrow end", c_if.addr_row_w, 32'd255);
                chk("big wcol end", c_if.addr_col_w, 32'd255);
                chk("big busy end", c_if.busy, 32'd1);
            end
            if (k == 65545) begin
                chk("big busy off", c_if.busy, 32'd0);
                chk("big wrow wrap", c_if.addr_row_w, 32'd0);
            end
        end
        chk("big reads",   32'(nrd),     32'd65536);
        chk("big writes",  32'(nwr),     32'd65536);
        chk("big dones",   32'(ndone),   32'd1);
        chk("big done at", 32'(done_at), 32'd65545);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/scan_addr_ctrl.md
# scan_addr_ctrl

Parametrised raster-scan controller for the frame-buffer processing path. On a start request it issues one read per pixel over a ROWS x COLS frame in row-major order. It drives a matching write stream delayed by a fixed pipeline latency, so results land at the same coordinates they were read from. It replaces the fixed 256x256, 8-cycle controller with configurable geometry and latency, a busy/done handshake, and an optional stall.

## Interface
- ROW_W, 8: row address width; ROW_W >= clog2(ROWS)
- COL_W, 8: column address width; COL_W >= clog2(COLS)
- ROWS, 256: frame rows, >= 1
- COLS, 256: frame columns, >= 1
- LAT, 8: processing pipeline latency in advancing cycles, 1..64
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous active-low reset
- start  in  1  begin a frame scan; sampled only in IDLE
- stall  in  1  freeze scan (present only with SCAN_STALL_EN)
- act  out  1  processing stage holds valid data (rd delayed one advancing cycle)
- rd  out  1  read strobe for addr_row_r/addr_col_r
- wr  out  1  write strobe for addr_row_w/addr_col_w
- addr_row_r  out  ROW_W  read row
- addr_col_r  out  COL_W  read column
- addr_row_w  out  ROW_W  write row
- addr_col_w  out  COL_W  write column
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse after the final write

## Operation
- Reset: every output is 0, all counters are 0, and the FSM is in IDLE. Reset is honoured at any point, including mid-frame; no completion pulse is produced for the aborted frame.
- FSM states:
  - IDLE -> RUN on start.
  - RUN: reads issued; writes begin once LAT advancing cycles have elapsed. RUN -> DRAIN after the last read.
  - DRAIN: no reads, writes continue. DRAIN -> DONE after the last write.
  - DONE: one cycle. DONE -> IDLE.
- start is ignored while busy (RUN, DRAIN, DONE).
- Read counter:
  - Column increments each read.
  - At COLS-1 the column wraps to 0 and the row increments.
  - After the last pixel (ROWS-1, COLS-1), both addresses return to 0.
- Write counter: same sequence as the read counter, advanced by each wr.
- Valid delay line: LAT entries deep, shifting rd. wr is its output. act is rd registered once.
- Total reads = total writes = N = ROWS*COLS. The internal pixel counter is wide enough for N with no overflow.
- "Advancing cycle" means any cycle in which stall is low, or every cycle when stall is compiled out.

## Timing
- start is sampled high at edge 0 in IDLE.
- From edge 1, busy=1.
- rd=1 at cycles 1..N, with read address pixel k at cycle k+1.
- act=1 at cycles 2..N+1.
- wr=1 at cycles 1+LAT..N+LAT. Write address (0,0) appears at cycle 1+LAT.
- done=1 and busy=0 at cycle N+LAT+1.
- The next start is accepted from cycle N+LAT+1 (IDLE again at N+LAT+2; a start sampled at N+LAT+1 in DONE is ignored).
- Stall cycles:
  - rd, wr and act are forced to 0.
  - Addresses, the delay line and the FSM hold.
  - All timing above stretches by exactly the number of stall cycles.
  - busy stays 1; done is never asserted during a stall.
- When LAT >= N, rd and wr never overlap; DRAIN is entered with the write counter still at (0,0).

## Configuration
- SCAN_STALL_EN defined: the stall port exists and behaves as above.
- SCAN_STALL_EN undefined: there is no stall port, and every cycle advances.
- Cycle behaviour with stall tied 0 is identical to the undefined build.

## Test plan
- ROWS=4, COLS=3, LAT=2, start pulse at cycle 0 -> rd cycles 1..12, wr cycles 3..14, act cycles 2..13, done at 15, read address (1,0) at cycle 4, final write (3,2) at cycle 14.
- Same config with stall high at cycles 5 and 6 -> outputs low at cycles 5 and 6, addresses frozen, done moves to 17, address sequence unchanged.
- start re-pulsed at cycles 3 and 10 during a scan -> ignored; exactly 12 reads and 12 writes, a single done pulse.
- rst low at cycle 7 mid-scan -> all outputs 0 immediately; no done pulse; the next start runs a full clean frame from (0,0).
- ROWS=1, COLS=2, LAT=5 -> rd cycles 1..2, wr cycles 6..7, done at 8, no rd/wr overlap.
- Default 256x256, LAT=8 -> 65536 reads and 65536 writes, done at cycle 65545, row/column wrap correct at 255.
